simple_axi_slave_mem: RTL and testbench
=======================================

# simple_axi_slave_mem

Single-beat AXI4 memory responder: the slave end of the `simple_axi_master` link. It holds `DEPTH` 64-bit words of byte-addressable storage and services one write and one read at a time on independent channels. It returns OKAY, SLVERR or DECERR responses. It replaces ad-hoc bench slaves and serves as the on-chip scratch RAM behind the master.

## Interface
- `DEPTH`, default 16: number of 64-bit words; byte capacity is `DEPTH*8`.
- `BASE_ADDR`, default 32'h0: first byte address decoded by this slave.
- `i_clk` in 1: clock; single clock domain.
- `i_rst` in 1: reset, synchronous, active-high.
- `s_axi_awvalid` in 1, `s_axi_awready` out 1, `s_axi_awaddr` in 32, `s_axi_awsize` in 3, `s_axi_awlen` in 8: write address channel.
- `s_axi_wvalid` in 1, `s_axi_wready` out 1, `s_axi_wdata` in 64, `s_axi_wstrb` in 8, `s_axi_wlast` in 1: write data channel.
- `s_axi_bvalid` out 1, `s_axi_bready` in 1, `s_axi_bresp` out 2: write response channel.
- `s_axi_arvalid` in 1, `s_axi_arready` out 1, `s_axi_araddr` in 32, `s_axi_arsize` in 3, `s_axi_arlen` in 8: read address channel.
- `s_axi_rvalid` out 1, `s_axi_rready` in 1, `s_axi_rdata` out 64, `s_axi_rresp` out 2, `s_axi_rlast` out 1: read data channel.
- The master's burst, cache, prot, lock and qos outputs are left unconnected; the slave ignores them.

## Operation
**Write FSM states:** `W_IDLE`, `W_RESP`.
- In `W_IDLE`, AW and W are captured independently, in either order or in the same cycle.
  - `awready` is high while AW is not yet captured.
  - `wready` is high while W is not yet captured.
  - A handshake is `valid & ready` at a rising edge.
- When both AW and W are held, the FSM commits:
  - Memory is updated at that edge. Byte lane k is written if `wstrb[k]`.
  - The word index is `(awaddr-BASE_ADDR)>>3`.
  - The FSM enters `W_RESP`.
- In `W_RESP`, `bvalid`=1 and `bresp` is held until `bready`, then the FSM returns to `W_IDLE`.

**Read FSM states:** `R_IDLE`, `R_DATA`.
- In `R_IDLE`, `arready`=1.
- On AR handshake:
  - the addressed word (or zero on error) is registered into `rdata`;
  - `rresp` is set;
  - the FSM enters `R_DATA`.
- In `R_DATA`, `rvalid`=1 and `rlast`=1 are held until `rready`.

**Error decode**, same rules for AW and AR, first match wins:
- Address outside `[BASE_ADDR, BASE_ADDR+DEPTH*8)` → DECERR (2'b11).
- Any of the following → SLVERR (2'b10):
  - `len`≠0;
  - `size`>3;
  - address not a multiple of `1<<size`;
  - write only: `wlast`=0.
- Otherwise → OKAY (2'b00).
- On any error: no memory write; `rdata`=0.

**Channel independence:** read and write run concurrently. If a write commit and an AR handshake occur at the same edge, the read returns the old data.

## Timing
- **Reset:** all ready, valid and `rlast` outputs are 0; `bresp`, `rresp` and `rdata` are 0; both FSMs are in idle; capture flags are cleared.
  - Memory contents are not reset.
  - `awready`, `wready` and `arready` rise on the first edge after `i_rst` falls.
- Reset asserted mid-transaction aborts it. Any pending response is dropped, and no partial write occurs unless the commit edge has already passed.
- **Write latency:** AW and W handshakes at the same edge N → `bvalid` high from N+1.
- **Read latency:** AR handshake at edge N → `rvalid` high from N+1.
- `bvalid`/`rvalid` and their payloads stay stable until accepted. The accepting edge deasserts them, and the matching ready re-asserts at that same edge.
- Ready signals never depend combinationally on valid inputs.

## Configuration
- **`SIMPLE_AXI_SLAVE_WAIT_EN` defined:**
  - Adds input `i_wait_cycles` (8 bits).
  - An internal counter loads `i_wait_cycles` when each FSM leaves idle-acceptance, and on reset.
  - `awready`, `wready` and `arready` are forced low while their channel's counter is nonzero. Each counter decrements once per cycle.
  - A value of 0 behaves identically to the build without the macro.
- **Undefined:** no port, no counter; zero wait states.

## Structure
- Shared package `simple_axi_pkg`:
  - `axi_resp_t` enum: OKAY, EXOKAY, SLVERR, DECERR;
  - size constants: BYTE=0, HALF=1, WORD=2, DWORD=3;
  - `wr_state_t` and `rd_state_t`.
- One sub-module, `axi_bytemem`: a `DEPTH`×64 array with one byte-strobed write port and one asynchronous read port. The parent registers the read output.

## Test plan
- **Write lane:** AW 0x2, size 1, `wstrb` 8'h0C, data 0xABCD0000 → OKAY; bytes [2]=CD, [3]=AB; other bytes unchanged.
- **Write ordering:** W presented 3 cycles before AW → both captured; `bvalid` exactly one cycle after the AW handshake; OKAY.
- **Read:** after a dword write of 0x11DD11DD22EE22EE to 0x8, a read of 0x8 size 3 → `rdata`=0x11DD11DD22EE22EE, `rlast`=1, OKAY; `rvalid` held for 4 cycles with `rready`=0.
- **Errors:**
  - read 0x3 size 2 → SLVERR, `rdata`=0;
  - write 0x80 with DEPTH=16 → DECERR, memory unchanged;
  - `awlen`=1 → SLVERR.
- **Concurrent:** same-edge write commit of 0x30 and AR to 0x30 → read returns the old value; a subsequent read returns the new value.
- **Wait states (macro on):** `i_wait_cycles`=5 → `arready` low for 5 cycles after reset, then a normal read completes.

Source files
------------

// File: rtl/simple_axi_pkg.sv
// -----------------------------------------------------------------------------
// simple_axi_pkg
// Shared types and helpers for the simple AXI link.
//   axi_resp_t  : AXI response encoding (OKAY, EXOKAY, SLVERR, DECERR)
//   BYTE..DWORD : transfer size encodings for AxSIZE
//   wr_state_t  : slave write-channel FSM states
//   rd_state_t  : slave read-channel FSM states
//   decode_resp : common error decode used by both AW and AR paths
// -----------------------------------------------------------------------------
package simple_axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  localparam logic [2:0] BYTE  = 3'd0;
  localparam logic [2:0] HALF  = 3'd1;
  localparam logic [2:0] WORD  = 3'd2;
  localparam logic [2:0] DWORD = 3'd3;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Address range failure outranks every slave error; among the slave
  // errors the order does not matter since they all map to SLVERR.
  function automatic axi_resp_t decode_resp(input logic       in_range,
                                            input logic [2:0] size,
                                            input logic [7:0] len,
                                            input logic [2:0] addr_lo,
                                            input logic       last_ok);
    logic [2:0] align_mask;
    align_mask = 3'((4'd1 << size) - 4'd1);
    if (!in_range)
      return DECERR;
    else if ((len != 8'd0) || (size > DWORD) ||
             ((addr_lo & align_mask) != 3'd0) || !last_ok)
      return SLVERR;
    else
      return OKAY;
  endfunction

endpackage

// File: rtl/axi_bytemem.sv
// -----------------------------------------------------------------------------
// axi_bytemem
// DEPTH x 64-bit storage with one byte-strobed synchronous write port and one
// asynchronous read port. Contents are not reset.
//   i_clk    : clock
//   i_we     : write enable (qualified by i_wstrb per byte lane)
//   i_waddr  : write word index
//   i_wdata  : write data
//   i_wstrb  : byte lane enables
//   i_raddr  : read word index
//   o_rdata  : combinational read data (old contents during a same-edge write)
// -----------------------------------------------------------------------------
module axi_bytemem #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [63:0]      i_wdata,
  input  logic [7:0]       i_wstrb,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [63:0]      o_rdata
);

  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int k = 0; k < 8; k++) begin
        if (i_wstrb[k]) mem_q[i_waddr][k*8 +: 8] <= i_wdata[k*8 +: 8];
      end
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/simple_axi_slave_mem.sv
// -----------------------------------------------------------------------------
// simple_axi_slave_mem
// Single-beat AXI4 memory slave with independent write and read channels.
// Optional wait states are enabled by defining SIMPLE_AXI_SLAVE_WAIT_EN.
// Parameters: DEPTH (64-bit words), BASE_ADDR (first decoded byte address).
// Ports:
//   i_wait_cycles : (SIMPLE_AXI_SLAVE_WAIT_EN only) wait states per channel
//   i_clk, i_rst  : clock, synchronous active-high reset
//   s_axi_aw*     : write address channel (valid/ready/addr/size/len)
//   s_axi_w*      : write data channel (valid/ready/data/strb/last)
//   s_axi_b*      : write response channel (valid/ready/resp)
//   s_axi_ar*     : read address channel (valid/ready/addr/size/len)
//   s_axi_r*      : read data channel (valid/ready/data/resp/last)
// -----------------------------------------------------------------------------
module simple_axi_slave_mem
  import simple_axi_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
  input  logic [7:0]  i_wait_cycles,
`endif
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic [7:0]  s_axi_awlen,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic [7:0]  s_axi_arlen,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast
);

  localparam int          IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH * 8);

  function automatic logic addr_in_range(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < DEPTH_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 3);
  endfunction

  wr_state_t   wr_state_q, wr_state_d;
  rd_state_t   rd_state_q, rd_state_d;
  logic        ready_en_q, ready_en_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [7:0]  awlen_q, awlen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        wlast_q, wlast_d;
  axi_resp_t   bresp_q, bresp_d, wr_resp;
  axi_resp_t   rresp_q, rresp_d, rd_resp;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] mem_rdata;
  logic        wr_commit, mem_we;
  logic        aw_fire, w_fire, ar_fire;
  logic        wr_wait_ok, rd_wait_ok;

  // Wait-state counters reload on reset and whenever a channel leaves idle,
  // then count down; acceptance is blocked until they reach zero.
`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
  logic [7:0] wr_wait_q, wr_wait_d, rd_wait_q, rd_wait_d;

  always_comb begin
    wr_wait_d = (wr_wait_q != 8'd0) ? wr_wait_q - 8'd1 : 8'd0;
    rd_wait_d = (rd_wait_q != 8'd0) ? rd_wait_q - 8'd1 : 8'd0;
    if (wr_commit) wr_wait_d = i_wait_cycles;
    if (ar_fire)   rd_wait_d = i_wait_cycles;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_wait_q <= i_wait_cycles;
      rd_wait_q <= i_wait_cycles;
    end else begin
      wr_wait_q <= wr_wait_d;
      rd_wait_q <= rd_wait_d;
    end
  end

  assign wr_wait_ok = (wr_wait_q == 8'd0);
  assign rd_wait_ok = (rd_wait_q == 8'd0);
`else
  assign wr_wait_ok = 1'b1;
  assign rd_wait_ok = 1'b1;
`endif

  // ready_en_q keeps every ready low during reset and releases them on the
  // first edge after reset drops; readies depend only on registered state.
  assign s_axi_awready = ready_en_q && (wr_state_q == W_IDLE) && !aw_held_q && wr_wait_ok;
  assign s_axi_wready  = ready_en_q && (wr_state_q == W_IDLE) && !w_held_q && wr_wait_ok;
  assign s_axi_arready = ready_en_q && (rd_state_q == R_IDLE) && rd_wait_ok;

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid && s_axi_wready;
  assign ar_fire = s_axi_arvalid && s_axi_arready;

  // Write channel: capture AW and W independently; commit on the edge where
  // both are held (including captures happening at that same edge).
  always_comb begin
    ready_en_d = 1'b1;
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    awsize_d   = awsize_q;
    awlen_d    = awlen_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wlast_d    = wlast_q;
    bresp_d    = bresp_q;
    wr_resp    = OKAY;
    wr_commit  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi_awaddr;
          awsize_d  = s_axi_awsize;
          awlen_d   = s_axi_awlen;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
          wlast_d  = s_axi_wlast;
        end
        if (aw_held_d && w_held_d) begin
          wr_resp    = decode_resp(addr_in_range(awaddr_d), awsize_d, awlen_d,
                                   awaddr_d[2:0], wlast_d);
          wr_commit  = 1'b1;
          bresp_d    = wr_resp;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) wr_state_d = W_IDLE;
      end
    endcase
  end

  assign mem_we = wr_commit && (wr_resp == OKAY);

  // Read channel: the memory read is asynchronous, so a same-edge write
  // commit is not yet visible and the read returns the old word.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_resp    = decode_resp(addr_in_range(s_axi_araddr), s_axi_arsize, s_axi_arlen,
                             s_axi_araddr[2:0], 1'b1);
    case (rd_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          rdata_d    = (rd_resp == OKAY) ? mem_rdata : 64'd0;
          rresp_d    = rd_resp;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) rd_state_d = R_IDLE;
      end
    endcase
  end

  // State and capture registers; memory contents live in axi_bytemem and are
  // deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ready_en_q <= 1'b0;
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= 32'd0;
      awsize_q   <= 3'd0;
      awlen_q    <= 8'd0;
      wdata_q    <= 64'd0;
      wstrb_q    <= 8'd0;
      wlast_q    <= 1'b0;
      bresp_q    <= OKAY;
      rresp_q    <= OKAY;
      rdata_q    <= 64'd0;
    end else begin
      ready_en_q <= ready_en_d;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      awsize_q   <= awsize_d;
      awlen_q    <= awlen_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wlast_q    <= wlast_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  axi_bytemem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (word_index(awaddr_d)),
    .i_wdata (wdata_d),
    .i_wstrb (wstrb_d),
    .i_raddr (word_index(s_axi_araddr)),
    .o_rdata (mem_rdata)
  );

  assign s_axi_bvalid = (wr_state_q == W_RESP);
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = (rd_state_q == R_DATA);
  assign s_axi_rlast  = (rd_state_q == R_DATA);
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_simple_axi_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_simple_axi_slave_mem
// Directed bench for simple_axi_slave_mem (DEPTH=16, BASE_ADDR=0): reset
// values, lane writes, W-before-AW ordering, read hold, error decode and
// same-edge write/read behaviour. With SIMPLE_AXI_SLAVE_WAIT_EN defined it
// also exercises wait states after reset.
// -----------------------------------------------------------------------------
module tb_simple_axi_slave_mem;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  wait_cycles;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awsize;
  logic [7:0]  s_axi_awlen;
  logic        s_axi_wvalid, s_axi_wready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arsize;
  logic [7:0]  s_axi_arlen;
  logic        s_axi_rvalid, s_axi_rready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;

  int total = 0;
  int bad   = 0;

  // 10 ns clock
  always #5 i_clk = ~i_clk;

  simple_axi_slave_mem #(
    .DEPTH     (16),
    .BASE_ADDR (32'h0)
  ) dut (
`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
    .i_wait_cycles (wait_cycles),
`endif
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast)
  );

  // Advance n rising edges; inputs change and outputs are sampled 1 ns later.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // AW and W presented together; bvalid expected one edge after the handshake.
  task automatic writeTxn(input string tag, input logic [31:0] addr, input logic [2:0] size,
                          input logic [7:0] len, input logic [63:0] data, input logic [7:0] strb,
                          input logic last, input logic [1:0] exp_resp);
    s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awsize = size; s_axi_awlen = len;
    s_axi_wvalid  = 1'b1; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last;
    applyStimulus(1);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checkOutput({tag, "_bvalid"}, 64'(s_axi_bvalid), 64'd1);
    checkOutput({tag, "_bresp"}, 64'(s_axi_bresp), 64'(exp_resp));
    s_axi_bready = 1'b1;
    applyStimulus(1);
    s_axi_bready = 1'b0;
    checkOutput({tag, "_bdone"}, 64'(s_axi_bvalid), 64'd0);
    checkOutput({tag, "_awready"}, 64'(s_axi_awready), 64'd1);
  endtask

  task automatic readTxn(input string tag, input logic [31:0] addr, input logic [2:0] size,
                         input logic [63:0] exp_data, input logic [1:0] exp_resp);
    s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arsize = size; s_axi_arlen = 8'd0;
    applyStimulus(1);
    s_axi_arvalid = 1'b0;
    checkOutput({tag, "_rvalid"}, 64'(s_axi_rvalid), 64'd1);
    checkOutput({tag, "_rdata"}, s_axi_rdata, exp_data);
    checkOutput({tag, "_rresp"}, 64'(s_axi_rresp), 64'(exp_resp));
    checkOutput({tag, "_rlast"}, 64'(s_axi_rlast), 64'd1);
    s_axi_rready = 1'b1;
    applyStimulus(1);
    s_axi_rready = 1'b0;
    checkOutput({tag, "_rdone"}, 64'(s_axi_rvalid), 64'd0);
    checkOutput({tag, "_arready"}, 64'(s_axi_arready), 64'd1);
  endtask

  initial begin
    i_rst = 1'b1; wait_cycles = 8'd0;
    s_axi_awvalid = 1'b0; s_axi_awaddr = 32'd0; s_axi_awsize = 3'd0; s_axi_awlen = 8'd0;
    s_axi_wvalid = 1'b0; s_axi_wdata = 64'd0; s_axi_wstrb = 8'd0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b0; s_axi_arvalid = 1'b0; s_axi_araddr = 32'd0; s_axi_arsize = 3'd0;
    s_axi_arlen = 8'd0; s_axi_rready = 1'b0;
    applyStimulus(3);

    // Reset state
    checkOutput("rst_awready", 64'(s_axi_awready), 64'd0);
    checkOutput("rst_wready", 64'(s_axi_wready), 64'd0);
    checkOutput("rst_arready", 64'(s_axi_arready), 64'd0);
    checkOutput("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    checkOutput("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    checkOutput("rst_rlast", 64'(s_axi_rlast), 64'd0);
    checkOutput("rst_bresp", 64'(s_axi_bresp), 64'd0);
    checkOutput("rst_rresp", 64'(s_axi_rresp), 64'd0);
    checkOutput("rst_rdata", s_axi_rdata, 64'd0);
    i_rst = 1'b0;
    #1;
    checkOutput("rel_awready_pre", 64'(s_axi_awready), 64'd0);
    applyStimulus(1);
    checkOutput("rel_awready", 64'(s_axi_awready), 64'd1);
    checkOutput("rel_wready", 64'(s_axi_wready), 64'd1);
    checkOutput("rel_arready", 64'(s_axi_arready), 64'd1);

    // Write lane: seed word 0, then overwrite bytes 2 and 3 only
    writeTxn("seed0", 32'h0, 3'd3, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 2'b00);
    writeTxn("lane", 32'h2, 3'd1, 8'd0, 64'h0000_0000_ABCD_0000, 8'h0C, 1'b1, 2'b00);
    readTxn("lane_rd", 32'h0, 3'd3, 64'h0123_4567_ABCD_CDEF, 2'b00);

    // Write ordering: W three cycles ahead of AW
    s_axi_wvalid = 1'b1; s_axi_wdata = 64'hCAFE_F00D_1234_5678; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1;
    applyStimulus(1);
    s_axi_wvalid = 1'b0;
    checkOutput("ord_wready", 64'(s_axi_wready), 64'd0);
    checkOutput("ord_awready", 64'(s_axi_awready), 64'd1);
    applyStimulus(2);
    checkOutput("ord_bvalid_early", 64'(s_axi_bvalid), 64'd0);
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h10; s_axi_awsize = 3'd3; s_axi_awlen = 8'd0;
    applyStimulus(1);
    s_axi_awvalid = 1'b0;
    checkOutput("ord_bvalid", 64'(s_axi_bvalid), 64'd1);
    checkOutput("ord_bresp", 64'(s_axi_bresp), 64'd0);
    s_axi_bready = 1'b1;
    applyStimulus(1);
    s_axi_bready = 1'b0;
    checkOutput("ord_bdone", 64'(s_axi_bvalid), 64'd0);
    readTxn("ord_rd", 32'h10, 3'd3, 64'hCAFE_F00D_1234_5678, 2'b00);

    // Read with rready held low for 4 cycles
    writeTxn("dw8", 32'h8, 3'd3, 8'd0, 64'h11DD_11DD_22EE_22EE, 8'hFF, 1'b1, 2'b00);
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h8; s_axi_arsize = 3'd3; s_axi_arlen = 8'd0;
    applyStimulus(1);
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("hold_rvalid", 64'(s_axi_rvalid), 64'd1);
      checkOutput("hold_rdata", s_axi_rdata, 64'h11DD_11DD_22EE_22EE);
      checkOutput("hold_arready", 64'(s_axi_arready), 64'd0);
      applyStimulus(1);
    end
    checkOutput("hold_rlast", 64'(s_axi_rlast), 64'd1);
    checkOutput("hold_rresp", 64'(s_axi_rresp), 64'd0);
    s_axi_rready = 1'b1;
    applyStimulus(1);
    s_axi_rready = 1'b0;
    checkOutput("hold_rdone", 64'(s_axi_rvalid), 64'd0);
    checkOutput("hold_arready_back", 64'(s_axi_arready), 64'd1);

    // Error decode
    readTxn("err_misalign", 32'h3, 3'd2, 64'd0, 2'b10);
    readTxn("err_rd_oor", 32'h80, 3'd3, 64'd0, 2'b11);
    readTxn("err_rd_size", 32'h0, 3'd4, 64'd0, 2'b10);
    writeTxn("err_wr_oor", 32'h80, 3'd3, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 2'b11);
    readTxn("err_oor_mem", 32'h0, 3'd3, 64'h0123_4567_ABCD_CDEF, 2'b00);
    writeTxn("err_awlen", 32'h8, 3'd3, 8'd1, 64'd0, 8'hFF, 1'b1, 2'b10);
    writeTxn("err_wlast", 32'h8, 3'd3, 8'd0, 64'd0, 8'hFF, 1'b0, 2'b10);
    readTxn("err_len_mem", 32'h8, 3'd3, 64'h11DD_11DD_22EE_22EE, 2'b00);

    // Concurrent write commit and AR to the same word
    writeTxn("cc_seed", 32'h30, 3'd3, 8'd0, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b1, 2'b00);
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h30; s_axi_awsize = 3'd3; s_axi_awlen = 8'd0;
    s_axi_wvalid = 1'b1; s_axi_wdata = 64'h5555_6666_7777_8888; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h30; s_axi_arsize = 3'd3; s_axi_arlen = 8'd0;
    applyStimulus(1);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    checkOutput("cc_bvalid", 64'(s_axi_bvalid), 64'd1);
    checkOutput("cc_rvalid", 64'(s_axi_rvalid), 64'd1);
    checkOutput("cc_rdata_old", s_axi_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    applyStimulus(1);
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    readTxn("cc_rd_new", 32'h30, 3'd3, 64'h5555_6666_7777_8888, 2'b00);

`ifdef SIMPLE_AXI_SLAVE_WAIT_EN
    // Wait states after reset
    wait_cycles = 8'd5;
    i_rst = 1'b1;
    applyStimulus(2);
    i_rst = 1'b0;
    applyStimulus(4);
    checkOutput("wait_arready_low", 64'(s_axi_arready), 64'd0);
    applyStimulus(1);
    checkOutput("wait_arready_high", 64'(s_axi_arready), 64'd1);
    readTxn("wait_rd", 32'h10, 3'd3, 64'hCAFE_F00D_1234_5678, 2'b00);
`endif

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
